hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised, scoreboard-based successor to the pipeline hazard unit for the 5-stage MIPS core. Each architectural register has a small countdown that holds the number of cycles until the pending result can be forwarded. The block also has a multi-cycle HI/LO (mult/div) busy tracker. From this state it produces the stall and bubble controls for the F/D/E boundary, which removes the fixed opcode-based stall equations. Forwarding-select generation stays in the existing forwarding logic; this block only decides stall/flush.

## Interface
Parameters:
- AW, 5, register address width (2**AW registers; register 0 never tracked)
- ALU_LAT, 1, countdown loaded for ALU-class producers (result forwardable from M)
- LD_LAT, 2, countdown loaded for load-class producers (result forwardable from W)
- MUL_LAT, 5, HI/LO busy cycles for mult/multu (1..63)
- DIV_LAT, 33, HI/LO busy cycles for div/divu (1..63)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- valid_d  in  1  D stage holds a valid instruction
- rs_d, rt_d  in  AW  D-stage source registers
- use_rs_d, use_rt_d  in  2  need class: 00 none, 01 needed in D (branch/jr), 10 needed in E
- wr_d  in  1  D instruction writes dst_d
- dst_d  in  AW  D-stage destination register
- ld_d  in  1  producer is load class (else ALU class)
- md_start_d, md_div_d  in  1  D is mult/div; md_div_d selects DIV_LAT
- md_use_d  in  1  D reads or writes HI/LO (mfhi/mflo/mthi/mtlo)
- kill_i  in  1  redirect: squash D and E this cycle
- stall_f, stall_d  out  1  hold PC and the D register
- flush_e  out  1  insert bubble into E
- md_busy  out  1  HI/LO unit busy

## Operation
- issue = valid_d & ~stall & ~kill_i. The D instruction moves to E this cycle.
- Per-register state cnt[r] (CW = 6 bits). Every cycle, each nonzero cnt decrements by 1, saturating at 0.
- On issue with wr_d & dst_d≠0: cnt[dst_d] ← ld_d ? LD_LAT : ALU_LAT. Issue overrides that register's decrement.
- Source hazard for rs (rt identical):
  - use=01 stalls if cnt[rs_d]≠0.
  - use=10 stalls if cnt[rs_d]>1.
  - Register 0 never stalls.
- HI/LO: md_cnt loaded with MUL_LAT/DIV_LAT on issue of md_start_d, and decrements to 0. md_busy = md_cnt≠0.
  - md_start_d or md_use_d while md_busy stalls.
- stall = valid_d & (rs hazard | rt hazard | md hazard). stall_f = stall_d = flush_e = stall.
- E tracking registers e_valid, e_wr, e_dst, e_md hold the last issued instruction and clear when nothing issues.
- kill_i with e_valid:
  - clears cnt[e_dst] if e_wr.
  - clears md_cnt if e_md.
- kill_i also blocks issue, so the D instruction is not recorded.
- Simultaneous kill clear and decrement on the same register: the clear wins.

## Timing
- Stall outputs are combinational from registered state plus D inputs, with no added latency. The state update is visible the next cycle.
- ALU producer issued at cycle t:
  - a need-D consumer stalls at t+1 and proceeds at t+2.
  - a need-E consumer never stalls.
- Load producer issued at t:
  - a need-D consumer stalls at t+1 and t+2.
  - a need-E consumer stalls at t+1 only.
- Divide issued at t: md_busy is high from t+1 through t+DIV_LAT.
- Reset (async assert, sync release): all cnt, md_cnt and e_* are 0. All outputs are 0. Reset mid-stall drops the stall immediately.

## Configuration
- HAZARD_SB_MD_EN defined: HI/LO tracker compiled in as above.
- Undefined:
  - md_cnt and e_md are removed.
  - md_start_d, md_div_d and md_use_d are ignored.
  - md_busy is tied 0.
  - HI/LO never stalls.

## Test plan
- Reset, then valid_d with use_rs_d=01: all outputs 0 during and after reset.
- lw $8 issued, next D is beq on rs=$8 (use=01): stall for exactly 2 cycles, then issue. With use=10: stall for 1 cycle.
- add $9 issued, next D is add using $9 (use=10): no stall. Same source with use=01: 1-cycle stall.
- Write to $0 followed by a consumer of $0: never stalls.
- div issued, then mflo: md_busy high for 33 cycles and mflo stalls for 33 cycles. With the macro undefined: no stall and md_busy=0.
- lw $8 issued, then kill_i the next cycle: cnt[$8] cleared, so a following beq on $8 does not stall. kill_i with valid_d: no issue, and flush_e=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based stall/bubble control for the F/D/E boundary of the 5-stage MIPS core.
// Define HAZARD_SB_MD_EN to compile in the HI/LO (mult/div) busy tracker.
module hazardCntLane #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] loadVal,
  input  logic          clr,
  output logic [CW-1:0] cnt
);
  // A kill clear wins over both a new load and the normal decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (load)       cnt <= loadVal;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
endmodule

module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int ALU_LAT = 1,
  parameter int LD_LAT  = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_d,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [1:0]    use_rs_d,
  input  logic [1:0]    use_rt_d,
  input  logic          wr_d,
  input  logic [AW-1:0] dst_d,
  input  logic          ld_d,
  input  logic          md_start_d,
  input  logic          md_div_d,
  input  logic          md_use_d,
  input  logic          kill_i,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          md_busy
);
  localparam int NREG = 1 << AW;
  localparam int CW   = 6;

  logic [NREG-1:0][CW-1:0] cnt;
  logic [CW-1:0]           loadVal;
  logic                    stall, issue, rsHaz, rtHaz, mdHaz, eKill;
  logic                    eValid, eWr;
  logic [AW-1:0]           eDst;

  // 01: value needed in D, so any pending count blocks; 10: needed in E, a count of 1 forwards from M.
  function automatic logic srcHaz(input logic [1:0] needCls, input logic [CW-1:0] c);
    srcHaz = ((needCls == 2'b01) && (c != '0)) || ((needCls == 2'b10) && (c > CW'(1)));
  endfunction

  assign rsHaz   = srcHaz(use_rs_d, cnt[rs_d]);
  assign rtHaz   = srcHaz(use_rt_d, cnt[rt_d]);
  assign stall   = valid_d & (rsHaz | rtHaz | mdHaz);
  assign issue   = valid_d & ~stall & ~kill_i;
  assign eKill   = kill_i & eValid;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign loadVal = ld_d ? CW'(LD_LAT) : CW'(ALU_LAT);

  assign cnt[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : gLane
    hazardCntLane #(.CW(CW)) uLane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (issue & wr_d & (dst_d == AW'(r))),
      .loadVal (loadVal),
      .clr     (eKill & eWr & (eDst == AW'(r))),
      .cnt     (cnt[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eValid <= 1'b0;
      eWr    <= 1'b0;
      eDst   <= '0;
    end else begin
      eValid <= issue;
      eWr    <= issue & wr_d;
      eDst   <= issue ? dst_d : '0;
    end
  end

`ifdef HAZARD_SB_MD_EN
  logic [CW-1:0] mdCnt;
  logic          eMd;

  assign md_busy = (mdCnt != '0);
  assign mdHaz   = (md_start_d | md_use_d) & md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt <= '0;
      eMd   <= 1'b0;
    end else begin
      eMd <= issue & md_start_d;
      if (eKill & eMd)              mdCnt <= '0;
      else if (issue & md_start_d)  mdCnt <= md_div_d ? CW'(DIV_LAT) : CW'(MUL_LAT);
      else if (mdCnt != '0)         mdCnt <= mdCnt - 1'b1;
    end
  end
`else
  logic unusedMd;
  assign unusedMd = ^{md_start_d, md_div_d, md_use_d};
  assign md_busy  = 1'b0;
  assign mdHaz    = 1'b0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; outputs checked as {stall_f, stall_d, flush_e, md_busy}.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_d, wr_d, ld_d, md_start_d, md_div_d, md_use_d, kill_i;
  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] use_rs_d, use_rt_d;
  logic       stall_f, stall_d, flush_e, md_busy;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mdExp;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs_d(rs_d), .rt_d(rt_d),
    .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .wr_d(wr_d), .dst_d(dst_d), .ld_d(ld_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d), .kill_i(kill_i),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {stall_f, stall_d, flush_e, md_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one D-stage instruction; md controls and kill default to 0.
  task automatic setD(input logic v, input logic [4:0] rs, input logic [1:0] urs,
                      input logic [4:0] rt, input logic [1:0] urt,
                      input logic wr, input logic [4:0] dst, input logic ld);
    valid_d = v; rs_d = rs; use_rs_d = urs; rt_d = rt; use_rt_d = urt;
    wr_d = wr; dst_d = dst; ld_d = ld;
    md_start_d = 1'b0; md_div_d = 1'b0; md_use_d = 1'b0; kill_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      setD(1'b0, 5'd0, 2'b00, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    setD(1'b1, 5'd8, 2'b01, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    #2 chk("reset_during", 4'b0000);
    tick(); tick();
    #2 chk("reset_held", 4'b0000);
    tick();
    rst_n = 1'b1;
    #2 chk("reset_after", 4'b0000);
    idle(2);

    // lw $8 then beq on $8 (need in D): two stall cycles
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1);
    #2 chk("lw_issue", 4'b0000);
    tick();
    setD(1'b1, 5'd8, 2'b01, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    #2 chk("lw_useD_t1", 4'b1110);
    tick();
    #2 chk("lw_useD_t2", 4'b1110);
    tick();
    #2 chk("lw_useD_t3", 4'b0000);
    tick();
    idle(3);

    // lw $8 then consumer needing $8 in E: one stall cycle
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1);
    tick();
    setD(1'b1, 5'd0, 2'b00, 5'd8, 2'b10, 1'b1, 5'd11, 1'b0);
    #2 chk("lw_useE_t1", 4'b1110);
    tick();
    #2 chk("lw_useE_t2", 4'b0000);
    tick();
    idle(3);

    // add $9 then add using $9 in E: no stall
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0);
    tick();
    setD(1'b1, 5'd9, 2'b10, 5'd0, 2'b00, 1'b1, 5'd12, 1'b0);
    #2 chk("alu_useE", 4'b0000);
    tick();
    idle(3);

    // add $9 then branch on rt=$9 (need in D): one stall cycle
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd9, 1'b0);
    tick();
    setD(1'b1, 5'd0, 2'b00, 5'd9, 2'b01, 1'b0, 5'd0, 1'b0);
    #2 chk("alu_useD_t1", 4'b1110);
    tick();
    #2 chk("alu_useD_t2", 4'b0000);
    tick();
    idle(3);

    // load into $0, then consumers of $0 never stall
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1);
    tick();
    setD(1'b1, 5'd0, 2'b01, 5'd0, 2'b10, 1'b0, 5'd0, 1'b0);
    #2 chk("reg0_t1", 4'b0000);
    tick();
    #2 chk("reg0_t2", 4'b0000);
    tick();
    idle(3);

    // lw $8 killed in E; the killed-cycle D (writes $10) must not be recorded
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1);
    tick();
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd10, 1'b1);
    kill_i = 1'b1;
    #2 chk("kill_no_flush", 4'b0000);
    tick();
    setD(1'b1, 5'd8, 2'b01, 5'd10, 2'b01, 1'b0, 5'd0, 1'b0);
    #2 chk("kill_cleared", 4'b0000);
    tick();
    idle(3);

    // reset asserted mid-stall drops the stall immediately
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd8, 1'b1);
    tick();
    setD(1'b1, 5'd8, 2'b01, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
    #2 chk("midstall_pre", 4'b1110);
    rst_n = 1'b0;
    #1 chk("midstall_reset", 4'b0000);
    tick();
    rst_n = 1'b1;
    #2 chk("midstall_release", 4'b0000);
    tick();
    idle(2);

    // div then mflo: 33 busy/stall cycles when the tracker is built in
`ifdef HAZARD_SB_MD_EN
    mdExp = 4'b1111;
`else
    mdExp = 4'b0000;
`endif
    setD(1'b1, 5'd4, 2'b10, 5'd5, 2'b10, 1'b0, 5'd0, 1'b0);
    md_start_d = 1'b1; md_div_d = 1'b1;
    #2 chk("div_issue", 4'b0000);
    tick();
    setD(1'b1, 5'd0, 2'b00, 5'd0, 2'b00, 1'b1, 5'd2, 1'b0);
    md_use_d = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      #2 chk($sformatf("mflo_t%0d", i), mdExp);
      tick();
    end
    #2 chk("mflo_done", 4'b0000);
    tick();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
